// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data memory with multi-cycle loads, lane steering and misalignment flag
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReqM,
    input  logic                  MemWriteM,
    input  logic [1:0]            SizeM,
    input  logic                  UnsignedM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  MemStallM,
    output logic                  MemErrM
);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t                r_state, w_next;
    logic [7:0]            r_mem [2**ADDR_WIDTH];
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_mis, w_load, w_store, w_cap, w_unused;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata, w_ext;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    assign w_unused = &{1'b0, ALUResultM[DATA_WIDTH-1:ADDR_WIDTH]};
    assign w_mis    = (SizeM == 2'b01 && ALUResultM[0]) || (SizeM[1] && ALUResultM[1:0] != 2'b00);
    assign w_be     = SizeM[1] ? 4'b1111 : (SizeM[0] ? 4'b0011 : 4'b0001) << ALUResultM[1:0];
    assign w_wdata  = WriteDataM << {ALUResultM[1:0], 3'b000};
    // The first load cycle reads live inputs; later cycles use the latched address
    assign w_raddr  = r_state == IDLE ? ALUResultM[ADDR_WIDTH-1:0] : r_addr;
    assign w_byte   = 8'(r_data >> {r_addr[1:0], 3'b000});
    assign w_half   = r_addr[1] ? r_data[31:16] : r_data[15:0];
    assign w_ext    = r_size == 2'b00 ? {{24{~r_unsigned & w_byte[7]}}, w_byte} :
                      r_size == 2'b01 ? {{16{~r_unsigned & w_half[15]}}, w_half} : r_data;
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_store   = 1'b0;
        w_cap     = 1'b0;
        MemStallM = 1'b0;
        MemErrM   = 1'b0;
        ReadDataM = '0;
        unique case (r_state)
            IDLE: begin
                w_load    = MemReqM && !MemWriteM && !w_mis;
                w_store   = MemReqM && MemWriteM && !w_mis;
                MemErrM   = MemReqM && w_mis;
                MemStallM = w_load;
                w_cap     = w_load && LATENCY == 1;
                if (w_load) w_next = LATENCY == 1 ? DONE : WAIT;
            end
            WAIT: begin
                MemStallM = 1'b1;
                w_cap     = r_cnt == CW'(1);
                if (w_cap) w_next = DONE;
            end
            DONE: begin
                ReadDataM = w_ext;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_data     <= '0;
        end else begin
            if (w_load) begin
                r_cnt      <= CW'(LATENCY - 1);
                r_addr     <= ALUResultM[ADDR_WIDTH-1:0];
                r_size     <= SizeM;
                r_unsigned <= UnsignedM;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_cap)
                r_data <= {r_mem[{w_raddr[ADDR_WIDTH-1:2], 2'd3}], r_mem[{w_raddr[ADDR_WIDTH-1:2], 2'd2}],
                           r_mem[{w_raddr[ADDR_WIDTH-1:2], 2'd1}], r_mem[{w_raddr[ADDR_WIDTH-1:2], 2'd0}]};
        end
    end
    // Contents survive reset; only a store in a non-reset cycle is committed
    always_ff @(posedge clk) begin
        if (reset && w_store)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[{ALUResultM[ADDR_WIDTH-1:2], 2'(i)}] <= w_wdata[8*i +: 8];
    end
endmodule
